sdram_mport_arbiter: RTL and testbench

Parametrised successor to the single-read/single-write SDRAM top-level arbiter. It sequences init, auto-refresh and NCH generic access engines (each a read or write engine) onto one SDRAM command/address/bank/DQ bus. Refresh always has priority; channels are served round-robin. Sits between the engine instances and the SDRAM pins.

---
 rtl/sdram_mport_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdram_mport_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mport_arbiter.sv
// rtl/sdram_mport_arbiter.sv - multi-channel SDRAM bus arbiter: init, refresh priority, round-robin channels
// Optional: define SDRAM_ARB_TIMEOUT_EN to abort AREF/GRANT after TIMEOUT cycles.
module sdram_mport_arbiter #(
  parameter int NCH     = 2,
  parameter int DQ_W    = 16,
  parameter int ADDR_W  = 13,
  parameter int BANK_W  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic                 flag_init_end,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_W-1:0]    init_addr,
  input  logic                 ref_req,
  output logic                 ref_en,
  input  logic                 flag_ref_end,
  input  logic [3:0]           ref_cmd,
  input  logic [ADDR_W-1:0]    ref_addr,
  input  logic [NCH-1:0]       ch_req,
  output logic [NCH-1:0]       ch_en,
  input  logic [NCH-1:0]       ch_end,
  input  logic [4*NCH-1:0]     ch_cmd,
  input  logic [ADDR_W*NCH-1:0] ch_addr,
  input  logic [BANK_W*NCH-1:0] ch_bank,
  input  logic [DQ_W*NCH-1:0]  ch_dq_out,
  input  logic [NCH-1:0]       ch_dq_oe,
  output logic [3:0]           sdram_cmd,
  output logic [ADDR_W-1:0]    sdram_addr,
  output logic [BANK_W-1:0]    sdram_bank,
  output logic [DQ_W-1:0]      sdram_dq_out,
  output logic                 sdram_dq_oe,
  output logic [NCH-1:0]       cur_ch,
  output logic                 err_timeout,
  output logic [NCH:0]         err_ch
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ARBIT = 4'b0010,
    AREF  = 4'b0100,
    GRANT = 4'b1000
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick;
  logic            found;
  logic [NCH-1:0]  win_oh;
  logic            expire;

  assign win_oh = NCH'(1) << win;
  assign cur_ch = (state == GRANT) ? win_oh : '0;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  assign expire = (cnt == CW'(TIMEOUT - 1));
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
  assign err_ch      = '0;
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state  <= IDLE;
      ptr    <= IW'(NCH - 1);
      win    <= '0;
      ref_en <= 1'b0;
      ch_en  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_ch      <= '0;
`endif
    end else begin
      ref_en <= (state == AREF);
      ch_en  <= (state == GRANT) ? win_oh : '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err_timeout <= 1'b0;
      if (state == AREF || state == GRANT) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
`endif
      case (state)
        IDLE: if (flag_init_end) state <= ARBIT;
        ARBIT: begin
          if (ref_req) begin
            state <= AREF;
          end else if (found) begin
            state <= GRANT;
            win   <= pick;
            ptr   <= pick;
          end
        end
        AREF: begin
          if (flag_ref_end) begin
            state <= ARBIT;
          end else if (expire) begin
            state <= ARBIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_timeout <= 1'b1;
            err_ch      <= {1'b1, {NCH{1'b0}}};
`endif
          end
        end
        GRANT: begin
          if (ch_end[win]) begin
            state <= ARBIT;
          end else if (expire) begin
            state <= ARBIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_timeout <= 1'b1;
            err_ch      <= {1'b0, win_oh};
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank and DQ enable are only ever driven by a granted channel.
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (state)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      GRANT: begin
        sdram_cmd    = ch_cmd[int'(win)*4 +: 4];
        sdram_addr   = ch_addr[int'(win)*ADDR_W +: ADDR_W];
        sdram_bank   = ch_bank[int'(win)*BANK_W +: BANK_W];
        sdram_dq_out = ch_dq_out[int'(win)*DQ_W +: DQ_W];
        sdram_dq_oe  = ch_dq_oe[win];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// tb/tb_sdram_mport_arbiter.sv - directed bench for sdram_mport_arbiter (NCH=2, TIMEOUT=15)
module tb_sdram_mport_arbiter;
  localparam int NCH = 2, DQ_W = 16, ADDR_W = 13, BANK_W = 2;

  logic                 sclk = 1'b0;
  logic                 s_rst_n;
  logic                 flag_init_end;
  logic [3:0]           init_cmd;
  logic [ADDR_W-1:0]    init_addr;
  logic                 ref_req, ref_en, flag_ref_end;
  logic [3:0]           ref_cmd;
  logic [ADDR_W-1:0]    ref_addr;
  logic [NCH-1:0]       ch_req, ch_en, ch_end, ch_dq_oe, cur_ch;
  logic [4*NCH-1:0]     ch_cmd;
  logic [ADDR_W*NCH-1:0] ch_addr;
  logic [BANK_W*NCH-1:0] ch_bank;
  logic [DQ_W*NCH-1:0]  ch_dq_out;
  logic [3:0]           sdram_cmd;
  logic [ADDR_W-1:0]    sdram_addr;
  logic [BANK_W-1:0]    sdram_bank;
  logic [DQ_W-1:0]      sdram_dq_out;
  logic                 sdram_dq_oe, err_timeout;
  logic [NCH:0]         err_ch;

  int total = 0;
  int passed = 0;

  always #5 sclk = ~sclk;

  sdram_mport_arbiter #(.NCH(NCH), .DQ_W(DQ_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .TIMEOUT(15)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .ch_req(ch_req), .ch_en(ch_en), .ch_end(ch_end), .ch_cmd(ch_cmd),
    .ch_addr(ch_addr), .ch_bank(ch_bank), .ch_dq_out(ch_dq_out), .ch_dq_oe(ch_dq_oe),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .cur_ch(cur_ch), .err_timeout(err_timeout), .err_ch(err_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic wait_ch_en(input string tag, input logic [NCH-1:0] exp);
    for (int i = 0; i < 100; i++) begin
      step();
      if (ch_en === exp) break;
    end
    chk(tag, 32'(ch_en), 32'(exp));
  endtask

  task automatic serve(input string tag, input logic [NCH-1:0] exp, input logic last);
    wait_ch_en({tag, "_grant"}, exp);
    chk({tag, "_cur"}, 32'(cur_ch), 32'(exp));
    chk({tag, "_cmd"}, 32'(sdram_cmd), exp[0] ? 32'h3 : 32'h5);
    repeat (9) step();
    ch_end = exp;
    step();
    ch_end = '0;
    if (last) ch_req = '0;
    wait_ch_en({tag, "_release"}, '0);
  endtask

  initial begin
    s_rst_n = 1'b0; flag_init_end = 1'b0; init_cmd = 4'b0010; init_addr = 13'h400;
    ref_req = 1'b0; flag_ref_end = 1'b0; ref_cmd = 4'b0001; ref_addr = 13'h0AA;
    ch_req = '0; ch_end = '0; ch_dq_oe = '0;
    ch_cmd = {4'b0101, 4'b0011};
    ch_addr = {13'h1F0, 13'h123};
    ch_bank = {2'b01, 2'b10};
    ch_dq_out = {16'hFFFF, 16'hA5A5};

    step();
    chk("rst_ref_en", 32'(ref_en), 0);
    chk("rst_ch_en", 32'(ch_en), 0);
    chk("rst_cur_ch", 32'(cur_ch), 0);
    chk("rst_err", 32'({err_timeout, err_ch}), 0);
    step();
    s_rst_n = 1'b1;

    // Init phase: IDLE passes init_cmd through for 200 cycles.
    repeat (200) step();
    chk("init_cmd", 32'(sdram_cmd), 32'h2);
    chk("init_addr", 32'(sdram_addr), 32'h400);
    chk("init_bank", 32'(sdram_bank), 0);
    flag_init_end = 1'b1;
    step();
    flag_init_end = 1'b0;
    init_cmd = 4'b0111;
    chk("arbit_nop", 32'(sdram_cmd), 32'h7);
    chk("arbit_addr", 32'(sdram_addr), 0);
    chk("arbit_grants", 32'({ref_en, ch_en}), 0);
    repeat (3) step();
    chk("arbit_idle_stay", 32'(ch_en), 0);

    // Round robin with both channels requesting.
    ch_req = 2'b11;
    serve("rr0", 2'b01, 1'b0);
    serve("rr1", 2'b10, 1'b0);
    serve("rr2", 2'b01, 1'b1);

    // Refresh wins over a simultaneous channel request.
    ref_req = 1'b1; ch_req = 2'b10;
    step();
    chk("aref_cur", 32'(cur_ch), 0);
    chk("aref_cmd", 32'(sdram_cmd), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h0AA);
    step();
    chk("aref_en", 32'(ref_en), 1);
    chk("aref_ch_en", 32'(ch_en), 0);
    ref_req = 1'b0;
    repeat (3) step();
    flag_ref_end = 1'b1;
    step();
    flag_ref_end = 1'b0;
    chk("post_aref_cur", 32'(cur_ch), 0);
    chk("post_aref_nop", 32'(sdram_cmd), 32'h7);
    chk("post_aref_ref_en", 32'(ref_en), 1);
    step();
    chk("ch1_cur", 32'(cur_ch), 32'h2);
    chk("ch1_en_late", 32'({ref_en, ch_en}), 0);
    step();
    chk("ch1_en", 32'(ch_en), 32'h2);
    ch_end = 2'b10; ch_req = '0;
    step();
    ch_end = '0;
    wait_ch_en("ch1_release", '0);

    // Data path mux for channel 0; foreign end pulse ignored.
    ch_req = 2'b01; ch_dq_oe = 2'b01;
    wait_ch_en("dp_grant", 2'b01);
    chk("dp_oe", 32'(sdram_dq_oe), 1);
    chk("dp_dq", 32'(sdram_dq_out), 32'hA5A5);
    chk("dp_bank", 32'(sdram_bank), 32'h2);
    chk("dp_addr", 32'(sdram_addr), 32'h123);
    ch_end = 2'b10;
    step();
    ch_end = '0;
    step();
    step();
    chk("dp_foreign_end", 32'({cur_ch, ch_en}), 32'h5);

    // Asynchronous reset in the middle of a grant.
    s_rst_n = 1'b0;
    #1;
    chk("midrst_ch_en", 32'(ch_en), 0);
    chk("midrst_cmd", 32'(sdram_cmd), 32'h7);
    chk("midrst_oe", 32'(sdram_dq_oe), 0);
    step();
    s_rst_n = 1'b1;
    init_cmd = 4'b0010;
    ch_req = 2'b11;
    repeat (5) step();
    chk("postrst_idle", 32'({cur_ch, ch_en}), 0);
    chk("postrst_cmd", 32'(sdram_cmd), 32'h2);
    flag_init_end = 1'b1;
    step();
    flag_init_end = 1'b0;
    init_cmd = 4'b0111;
    serve("postrst", 2'b01, 1'b1);

    // Channel 1 never ends.
    ch_req = 2'b10;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cur_ch === 2'b10) break;
    end
    chk("to_enter", 32'(cur_ch), 32'h2);
    repeat (14) step();
    chk("to_before", 32'({err_timeout, cur_ch}), 32'h2);
    step();
`ifdef SDRAM_ARB_TIMEOUT_EN
    ch_req = '0;
    chk("to_pulse", 32'(err_timeout), 1);
    chk("to_err_ch", 32'(err_ch), 32'h2);
    chk("to_cur", 32'(cur_ch), 0);
    chk("to_en_lag", 32'(ch_en), 32'h2);
    step();
    chk("to_pulse_end", 32'(err_timeout), 0);
    chk("to_en_drop", 32'(ch_en), 0);
    chk("to_err_hold", 32'(err_ch), 32'h2);
`else
    repeat (25) step();
    chk("noto_wait", 32'({cur_ch, ch_en}), 32'hA);
    chk("noto_err", 32'({err_timeout, err_ch}), 0);
    ch_end = 2'b10; ch_req = '0;
    step();
    ch_end = '0;
    wait_ch_en("noto_release", '0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
